// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg: constants and types shared by the XOR stream encoder and
// decoder. Both ends must use the same LFSR taps and default seed, so they
// are kept here.
//   LFSR_TAPS    - Fibonacci feedback mask (x^8+x^6+x^5+x^4+1)
//   DEFAULT_SEED - key used after reset and substituted for a zero seed
//   state_t      - stream FSM states
//   lfsr_step    - one step of the keystream generator
package xor_stream_pkg;

  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  // Fibonacci left shift: the feedback bit is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] k,
                                           input logic [7:0] taps);
    return {k[6:0], ^(k & taps)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit keystream register for the XOR stream decoder.
// Ports:
//   clk      in  - rising-edge clock
//   reset    in  - asynchronous, active-high; key returns to DEFAULT_SEED
//   load     in  - load load_val (zero replaced by DEFAULT_SEED); wins over advance
//   load_val in  - seed value
//   advance  in  - step the LFSR once
//   key      out - current key byte
module lfsr8 #(
  parameter logic [7:0] TAPS         = xor_stream_pkg::LFSR_TAPS,
  parameter logic [7:0] DEFAULT_SEED = xor_stream_pkg::DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       advance,
  output logic [7:0] key
);
  import xor_stream_pkg::*;

  logic [7:0] key_q;

  // A zero seed would lock the LFSR at zero forever, so it is replaced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= DEFAULT_SEED;
    end else if (load) begin
      key_q <= (load_val == 8'h00) ? DEFAULT_SEED : load_val;
    end else if (advance) begin
      key_q <= lfsr_step(key_q, TAPS);
    end
  end

  assign key = key_q;

endmodule

// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder: recovers plaintext bytes from a cipher stream by XORing
// each byte with an LFSR keystream. Valid/ready on both sides, one output
// register stage.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   seed_load   - pulse: load seed, restart stream, drop any pending byte
//   seed        - seed value sampled with seed_load
//   in_valid / in_ready / cipher  - input byte handshake
//   out_valid / out_ready / plain - output byte handshake
//   byte_count  - bytes decoded since last seed_load or reset (wraps)
module xor_stream_decoder #(
  parameter logic [7:0] TAPS         = xor_stream_pkg::LFSR_TAPS,
  parameter logic [7:0] DEFAULT_SEED = xor_stream_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  cipher,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  plain,
  output logic [15:0] byte_count
);
  import xor_stream_pkg::*;

  state_t      state_q, state_d;
  logic [7:0]  key;
  logic        accept;
  logic [7:0]  plain_p1;
  logic        vld_p1;
  logic [15:0] cnt_q;

  lfsr8 #(
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed),
    .advance  (accept),
    .key      (key)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNSEEDED;
    end else begin
      state_q <= state_d;
    end
  end

  // seed_load blocks acceptance in its own cycle so the byte is never XORed
  // with a key that is about to be replaced.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    if (seed_load) begin
      state_d = ST_RUN;
    end
    if (state_q == ST_RUN && !seed_load && (!vld_p1 || out_ready)) begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  // ---- stage p1: output register ----
  // An accept in the same cycle as a drain refills the slot, giving one byte
  // per cycle with out_ready held high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plain_p1 <= 8'h00;
      vld_p1   <= 1'b0;
      cnt_q    <= 16'd0;
    end else if (seed_load) begin
      vld_p1 <= 1'b0;
      cnt_q  <= 16'd0;
    end else if (accept) begin
      plain_p1 <= cipher ^ key;
      vld_p1   <= 1'b1;
      cnt_q    <= cnt_q + 16'd1;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign plain      = plain_p1;
  assign out_valid  = vld_p1;
  assign byte_count = cnt_q;

endmodule
